// File: rtl/axi_rx_fifo.sv
// axi_rx_fifo: DEPTH-entry first-word-fall-through receive FIFO for one VALID/READY channel
module axi_rx_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       VALID,
  output logic                       READY,
  input  logic [WIDTH-1:0]           xDATA,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       rx_valid,
  input  logic                       rx_pop,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic                       rx_almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = VALID & READY;
  assign pop = rx_pop & rx_valid;
  assign READY = rx_count != CW'(DEPTH);
  assign rx_valid = rx_count != '0;
  assign rx_almost_full = rx_count >= CW'(AF_LEVEL);
  assign rx_data = mem[rd_ptr];
  // storage is never cleared; writes are suppressed while reset is asserted
  always_ff @(posedge ACLK)
    if (push && !ARESET) mem[wr_ptr] <= xDATA;
  // pointers wrap naturally; full vs empty is told apart by the count
  always_ff @(posedge ACLK)
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      rx_count <= rx_count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_axi_rx_fifo.sv
// tb_axi_rx_fifo: directed self-checking bench for axi_rx_fifo
module tb_axi_rx_fifo;
  logic ACLK = 0, ARESET, VALID, READY, rx_valid, rx_pop, rx_almost_full;
  logic [7:0] xDATA, rx_data;
  logic [2:0] rx_count;
  int vectors = 0, miscompares = 0;
  axi_rx_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .VALID(VALID), .READY(READY), .xDATA(xDATA),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .rx_count(rx_count),
    .rx_almost_full(rx_almost_full)
  );
  always #5 ACLK = ~ACLK;
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic flags(input string tag, input int cnt, input logic rdy, input logic vld, input logic af);
    chk({tag, "_count"}, 32'(rx_count), 32'(cnt));
    chk({tag, "_ready"}, 32'(READY), 32'(rdy));
    chk({tag, "_valid"}, 32'(rx_valid), 32'(vld));
    chk({tag, "_af"}, 32'(rx_almost_full), 32'(af));
  endtask
  initial begin
    logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] order [4] = '{8'hA9, 8'hB0, 8'hB1, 8'h99};
    ARESET = 1; VALID = 0; rx_pop = 0; xDATA = 0;
    tick(); tick();
    ARESET = 0;
    flags("reset", 0, 1, 0, 0);
    VALID = 1;
    for (int i = 0; i < 4; i++) begin
      xDATA = fill[i];
      tick();
      flags("fill", i + 1, i < 3, 1, i >= 2);
      chk("fill_head", 32'(rx_data), 32'h11);
    end
    xDATA = 8'h55;
    tick();
    flags("full_hold", 4, 0, 1, 1);
    VALID = 0; rx_pop = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(rx_data), 32'(fill[i]));
      tick();
      chk("drain_count", 32'(rx_count), 32'(3 - i));
    end
    flags("drained", 0, 1, 0, 0);
    tick();
    flags("underflow", 0, 1, 0, 0);
    rx_pop = 0; VALID = 1;
    xDATA = 8'hA0; tick();
    xDATA = 8'hA1; tick();
    chk("pp_pre_head", 32'(rx_data), 32'hA0);
    rx_pop = 1;
    for (int i = 0; i < 8; i++) begin
      xDATA = 8'hA2 + 8'(i);
      tick();
      chk("pp_count", 32'(rx_count), 32'd2);
      chk("pp_head", 32'(rx_data), 32'(8'hA1 + 8'(i)));
    end
    rx_pop = 0;
    xDATA = 8'hB0; tick();
    xDATA = 8'hB1; tick();
    flags("refull", 4, 0, 1, 1);
    xDATA = 8'h99; rx_pop = 1;
    tick();
    flags("full_pop", 3, 1, 1, 1);
    chk("full_pop_head", 32'(rx_data), 32'hA9);
    rx_pop = 0;
    tick();
    flags("late_accept", 4, 0, 1, 1);
    VALID = 0; rx_pop = 1;
    for (int i = 0; i < 4; i++) begin
      chk("order_data", 32'(rx_data), 32'(order[i]));
      tick();
    end
    flags("empty2", 0, 1, 0, 0);
    rx_pop = 0; VALID = 1;
    xDATA = 8'hC0; tick();
    xDATA = 8'hC1; tick();
    xDATA = 8'hC2; tick();
    flags("pre_rst", 3, 1, 1, 1);
    ARESET = 1; xDATA = 8'hC3; rx_pop = 1;
    tick();
    ARESET = 0; VALID = 0; rx_pop = 0;
    flags("mid_rst", 0, 1, 0, 0);
    VALID = 1; xDATA = 8'h5A;
    tick();
    VALID = 0;
    flags("post_rst", 1, 1, 1, 0);
    chk("post_rst_head", 32'(rx_data), 32'h5A);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
